// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised RAM serving one load/store at a time after LATENCY wait states.
// Optional access-error checking is enabled by defining DMEM_ERR_EN.
module dmem_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_err
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [3:0]  LAT   = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state, state_next;
    logic [3:0]        cnt, cnt_next;
    logic              accept, enter_resp;

    logic              lat_read, lat_write;
    logic [2:0]        lat_f3;
    logic [31:0]       lat_addr, lat_wdata;

    logic              src_read, src_write;
    logic [2:0]        src_f3;
    logic [31:0]       src_addr, src_wdata;

    logic              is_load, is_store, sz_byte, sz_half;
    logic [1:0]        lane;
    logic [IDX_W-1:0]  idx;
    logic              acc_err;
    logic              do_write;

    logic [31:0]       ram [DEPTH];
    logic [31:0]       word;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_data;
    logic [3:0]        st_be;
    logic [31:0]       st_data;

    // State and wait counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (mem_read || mem_write) begin
                    accept = 1'b1;
                    if (LAT == 4'd0) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                        cnt_next   = 4'd0;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = LAT;
                    end
                end
            end
            WAIT: begin
                if (cnt <= 4'd1) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request capture at accept; later input changes are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_read  <= 1'b0;
            lat_write <= 1'b0;
            lat_f3    <= 3'd0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
        end else if (accept) begin
            lat_read  <= mem_read;
            lat_write <= mem_write;
            lat_f3    <= funct3;
            lat_addr  <= mem_addr;
            lat_wdata <= mem_wdata;
        end
    end

    // With zero wait states the access happens on the accept edge, so use live inputs in IDLE
    always_comb begin
        if (state == IDLE) begin
            src_read  = mem_read;
            src_write = mem_write;
            src_f3    = funct3;
            src_addr  = mem_addr;
            src_wdata = mem_wdata;
        end else begin
            src_read  = lat_read;
            src_write = lat_write;
            src_f3    = lat_f3;
            src_addr  = lat_addr;
            src_wdata = lat_wdata;
        end
    end

    // Access decode; store funct3 1xx and any 011/11x fall back to word size
    always_comb begin
        is_store = src_write;
        is_load  = src_read & ~src_write;
        sz_byte  = (src_f3[1:0] == 2'b00) && !(is_store && src_f3[2]);
        sz_half  = (src_f3[1:0] == 2'b01) && !(is_store && src_f3[2]);
        lane     = src_addr[1:0];
        idx      = IDX_W'((src_addr - BASE_ADDR) >> 2);
    end

`ifdef DMEM_ERR_EN
    logic [31:0] offset;
    logic        misaligned, out_of_range, illegal, conflict;

    always_comb begin
        offset       = src_addr - BASE_ADDR;
        misaligned   = (sz_half && src_addr[0]) ||
                       (!sz_byte && !sz_half && (src_addr[1:0] != 2'b00));
        out_of_range = (src_addr < BASE_ADDR) || ((offset >> (IDX_W + 2)) != 32'd0);
        illegal      = is_store ? ((src_f3 == 3'b011) || src_f3[2])
                                : ((src_f3 == 3'b011) || (src_f3 == 3'b110) || (src_f3 == 3'b111));
        conflict     = src_read & src_write;
        acc_err      = misaligned | out_of_range | illegal | conflict;
    end
`else
    assign acc_err = 1'b0;
`endif

    // Load extraction and extension
    always_comb begin
        word = ram[idx];
        case (lane)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = lane[1] ? word[31:16] : word[15:0];
        if (sz_byte) begin
            load_data = src_f3[2] ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        end else if (sz_half) begin
            load_data = src_f3[2] ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
        end else begin
            load_data = word;
        end
    end

    // Store lane enables with replicated data
    always_comb begin
        if (sz_byte) begin
            st_be   = 4'b0001 << lane;
            st_data = {4{src_wdata[7:0]}};
        end else if (sz_half) begin
            st_be   = lane[1] ? 4'b1100 : 4'b0011;
            st_data = {2{src_wdata[15:0]}};
        end else begin
            st_be   = 4'b1111;
            st_data = src_wdata;
        end
    end

    assign do_write = enter_resp & is_store & ~acc_err;

    always_ff @(posedge clk) begin
        if (do_write && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b]) ram[idx][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
    end

    // Response registers, loaded on entry into RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rdata <= 32'd0;
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
        end else if (enter_resp) begin
            mem_ready <= 1'b1;
            mem_err   <= acc_err;
            mem_rdata <= (is_load && !acc_err) ? load_data : 32'd0;
        end else begin
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
        end
    end

endmodule
